// File: rtl/traffic_signal_monitor.sv
// rtl/traffic_signal_monitor.sv - passive checker for the four-lamp traffic signal bus
module traffic_signal_monitor #(
    parameter int MIN_AMBER  = 3,
    parameter int MIN_ALLRED = 2,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        clr,
    input  logic [1:0]  highway_signal_1,
    input  logic [1:0]  highway_signal_2,
    input  logic [1:0]  farm_signal_1,
    input  logic [1:0]  farm_signal_2,
    output logic        err_sequence,
    output logic        err_amber,
    output logic        err_conflict,
    output logic        err_allred,
    output logic [3:0]  err_lamp,
    output logic        err_pulse,
    output logic [1:0]  active_group,
    output logic [15:0] rotations
);
    localparam logic [1:0] GREEN   = 2'b00;
    localparam logic [1:0] YELLOW  = 2'b01;
    localparam logic [1:0] RED     = 2'b10;
    localparam logic [1:0] RED_YEL = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] AMBER_MIN  = CNT_W'(MIN_AMBER);
    localparam logic [CNT_W-1:0] ALLRED_MIN = CNT_W'(MIN_ALLRED);

    typedef enum logic [1:0] {
        GRP_NONE     = 2'b00,
        GRP_HW       = 2'b01,
        GRP_FARM     = 2'b10,
        GRP_CONFLICT = 2'b11
    } group_t;

    logic [3:0][1:0]       cur_code;
    logic [3:0][1:0]       prev_code;
    logic [3:0][CNT_W-1:0] dwell;
    logic [3:0][CNT_W-1:0] dwell_nxt;
    logic [3:0]            seq_hit;
    logic [3:0]            amb_hit;
    logic [CNT_W-1:0]      allred_cnt;
    logic [CNT_W-1:0]      allred_nxt;
    logic                  hw_act;
    logic                  farm_act;
    logic                  conflict_hit;
    logic                  allred_hit;
    logic                  rot_hit;
    group_t                cur_group;
    group_t                last_group;
    group_t                last_group_nxt;

    assign cur_code = {farm_signal_2, farm_signal_1, highway_signal_2, highway_signal_1};

    // Lamp cycle is 10 -> 11 -> 00 -> 01 -> 10; holding any code is legal.
    function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
        case ({from, to})
            {RED, RED_YEL}, {RED_YEL, GREEN}, {GREEN, YELLOW}, {YELLOW, RED}: return 1'b1;
            default: return from == to;
        endcase
    endfunction

    always_comb begin
        seq_hit   = '0;
        amb_hit   = '0;
        dwell_nxt = dwell;
        for (int i = 0; i < 4; i++) begin
            if (cur_code[i] != prev_code[i]) begin
                seq_hit[i]   = !legal_step(prev_code[i], cur_code[i]);
                amb_hit[i]   = (prev_code[i] == YELLOW || prev_code[i] == RED_YEL) &&
                               (dwell[i] < AMBER_MIN);
                dwell_nxt[i] = go ? CNT_ONE : '0;
            end else if (go && dwell[i] != CNT_MAX) begin
                dwell_nxt[i] = dwell[i] + CNT_ONE;
            end
        end
    end

    always_comb begin
        hw_act         = (cur_code[0] != RED) || (cur_code[1] != RED);
        farm_act       = (cur_code[2] != RED) || (cur_code[3] != RED);
        cur_group      = group_t'({farm_act, hw_act});
        conflict_hit   = hw_act && farm_act;
        allred_hit     = 1'b0;
        rot_hit        = 1'b0;
        last_group_nxt = last_group;
        allred_nxt     = allred_cnt;
        // allred_cnt still holds the clearance seen before this sample's group switch.
        if ((cur_group == GRP_HW && last_group == GRP_FARM) ||
            (cur_group == GRP_FARM && last_group == GRP_HW)) begin
            allred_hit = allred_cnt < ALLRED_MIN;
        end
        if (cur_group == GRP_HW && last_group == GRP_FARM) begin
            rot_hit = 1'b1;
        end
        if (cur_group == GRP_HW || cur_group == GRP_FARM) begin
            last_group_nxt = cur_group;
        end
        if (hw_act || farm_act) begin
            allred_nxt = '0;
        end else if (go && allred_cnt != CNT_MAX) begin
            allred_nxt = allred_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_code    <= {4{RED}};
            dwell        <= '0;
            allred_cnt   <= '0;
            last_group   <= GRP_NONE;
            err_sequence <= 1'b0;
            err_amber    <= 1'b0;
            err_conflict <= 1'b0;
            err_allred   <= 1'b0;
            err_lamp     <= '0;
            err_pulse    <= 1'b0;
            active_group <= GRP_NONE;
            rotations    <= '0;
        end else begin
            prev_code    <= cur_code;
            dwell        <= dwell_nxt;
            allred_cnt   <= allred_nxt;
            last_group   <= last_group_nxt;
            // A fresh error outranks a simultaneous clear.
            err_sequence <= (err_sequence & ~clr) | (|seq_hit);
            err_amber    <= (err_amber & ~clr) | (|amb_hit);
            err_conflict <= (err_conflict & ~clr) | conflict_hit;
            err_allred   <= (err_allred & ~clr) | allred_hit;
            err_lamp     <= (err_lamp & {4{~clr}}) | seq_hit | amb_hit;
            err_pulse    <= (|seq_hit) | (|amb_hit) | conflict_hit | allred_hit;
            active_group <= cur_group;
            if (rot_hit) begin
                rotations <= rotations + 16'd1;
            end
        end
    end
endmodule

// File: doc/traffic_signal_monitor.md
# traffic_signal_monitor

Passive protocol checker sitting at the receiving end of the four-lamp signal bus driven by the traffic light controller. It decodes each 2-bit lamp code and, in go-qualified cycles, measures dwell times. It flags illegal lamp sequences, short amber phases, highway/farm conflicts and short all-red clearance intervals. It also counts completed highway/farm rotations for bench scoreboards and on-board diagnostics.

## Interface
- MIN_AMBER, 3, minimum go-qualified samples a lamp must hold 01 (yellow) or 11 (red+yellow)
- MIN_ALLRED, 2, minimum go-qualified all-red samples between farm and highway service
- CNT_W, 8, width of the saturating dwell counters
- clk  input  1  sampling clock, shared with the controller
- rst  input  1  reset, asynchronous, active-high
- go  input  1  controller advance enable; only samples with go=1 add to dwell
- clr  input  1  synchronous clear of sticky error flags and err_lamp
- highway_signal_1, highway_signal_2, farm_signal_1, farm_signal_2  input  2 each  lamp codes: 00 green, 01 yellow, 10 red, 11 red+yellow
- err_sequence  output  1  sticky: illegal lamp transition seen
- err_amber  output  1  sticky: 01/11 phase shorter than MIN_AMBER
- err_conflict  output  1  sticky: highway and farm non-red in same sample
- err_allred  output  1  sticky: group switch with all-red shorter than MIN_ALLRED
- err_lamp  output  4  sticky OR of lamps causing sequence/amber errors; [0]=hw1, [1]=hw2, [2]=farm1, [3]=farm2
- err_pulse  output  1  one-cycle pulse on any newly detected error
- active_group  output  2  00 none (all red), 01 highway, 10 farm, 11 conflict
- rotations  output  16  count of farm→highway handovers, wraps at 2^16

## Operation
- Every posedge clk samples all four codes; per-lamp registers hold the previous code and a dwell counter.
- Legal per-lamp transitions are hold, 10→11, 11→00, 00→01 and 01→10. Any other change sets err_sequence and the lamp's err_lamp bit.
- On a code change, the dwell counter restarts at go (1 or 0). While the code is held, the counter increments when go=1 and saturates at 2^CNT_W−1.
- Leaving 01 or 11 with previous dwell < MIN_AMBER sets err_amber and the lamp bit. This check runs independently of the legality check, so both can fire on one sample.
- Group decode per sample: highway active if either highway lamp ≠10; farm active likewise. Both active gives conflict: err_conflict is set and active_group=11.
- All-red counter: cleared when any lamp ≠10. Otherwise it increments on go=1 and saturates.
- last_group register holds the most recent non-none group, reset to none.
- Transition into highway or farm with last_group = the other group and all-red count < MIN_ALLRED sets err_allred.
- Transition into highway with last_group=farm increments rotations.
- The first activation after reset (last_group=none) is never checked or counted.
- Conflict samples do not update last_group.
- err_pulse is high for a sample if any sticky bit or err_lamp bit goes 0→1, or if an error condition recurs while its flag is already set.

## Timing
- Reset values: all err_* 0, err_lamp 0, err_pulse 0, active_group 00, rotations 0. Previous codes are reset to 10, dwell and all-red counters to 0, last_group to none.
- Latency: offending sample at edge N; flags and err_pulse are visible after edge N, for the cycle N..N+1.
- clr with a simultaneous new error: the new error wins (flag remains 1, err_pulse 1).
- go=0 stretches phases without error; a code change with go=0 is still checked for legality.
- rst asserted mid-operation clears all state immediately. After release, the first sample is compared against all-red previous codes.
- Controller cycle under continuous go: 125 go-cycles per rotation.

## Test plan
- Controller drives the bus, go=1 for 400 cycles after reset release: every err_* stays 0, err_pulse never fires, and rotations=3.
- Force hw1 10→00 with go=1: err_sequence=1, err_lamp=4'b0001, err_pulse high exactly one cycle, and err_amber stays 0.
- Drive hw2 01 for 2 go-samples, then 10: err_amber=1, err_lamp=4'b0010, and err_sequence stays 0.
- Drive hw1=00 and farm1=00 in the same sample: err_conflict=1, active_group=11, and rotations unchanged.
- Highway yellow, then all-red for 1 go-sample, then farm1=11: err_allred=1. Repeat with 2 all-red samples: no new error.
- Controller run with go toggling every 10 cycles and clr pulsed mid-amber: no errors and flags stay 0. Assert rst asynchronously mid-S8: all outputs go to reset values before the next clk edge.
